// File: rtl/fifo_rd_prefetch_pkg.sv
// Shared parameters, types and helpers for the sync FIFO first-word-fall-through output stage.
package fifo_rd_prefetch_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int PREFETCH_DEPTH     = 3;

  // Buffer operation for one clock, encoded as {push, pop}.
  typedef enum logic [1:0] {
    BUF_IDLE = 2'b00,
    BUF_POP  = 2'b01,
    BUF_PUSH = 2'b10,
    BUF_BOTH = 2'b11
  } buf_op_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Small circular buffer with explicit occupancy count and combinational head read,
// used as the prefetch store in front of the FIFO consumer.
module fifo_out_buf
  import fifo_rd_prefetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUF_DEPTH  = PREFETCH_DEPTH,
  parameter int CNT_WIDTH  = cnt_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam int PTR_WIDTH = ptr_width(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

  logic [PTR_WIDTH-1:0] head_reg, head_next;
  logic [PTR_WIDTH-1:0] tail_reg, tail_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;
  buf_op_e              op;

  function automatic logic [PTR_WIDTH-1:0] wrap_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    op         = buf_op_e'({push, pop});
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    case (op)
      BUF_PUSH: begin
        tail_next  = wrap_inc(tail_reg);
        count_next = count_reg + 1'b1;
      end
      BUF_POP: begin
        head_next  = wrap_inc(head_reg);
        count_next = count_reg - 1'b1;
      end
      BUF_BOTH: begin
        head_next = wrap_inc(head_reg);
        tail_next = wrap_inc(tail_reg);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Storage is not reset; count_reg alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[tail_reg] <= push_data;
    end
  end

  assign count     = count_reg;
  assign head_data = mem[head_reg];

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && (int'(count_reg) == BUF_DEPTH)));

  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    !(pop && (count_reg == '0)));

endmodule

// File: rtl/fifo_rd_prefetch.sv
// First-word-fall-through output stage: issues credit-limited reads to the read controller,
// captures the returning memory word one cycle later and presents it over valid/ready.
module fifo_rd_prefetch
  import fifo_rd_prefetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUF_DEPTH  = PREFETCH_DEPTH,
  parameter int CNT_WIDTH  = cnt_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_empty,
  output logic                  rd_ready,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout_data,
  input  logic                  dout_ready,
  output logic [CNT_WIDTH-1:0]  buf_count
);

  logic                  pending_reg, pending_next;
  logic                  fire;
  logic                  pop;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  credit_used;
  logic [DATA_WIDTH-1:0] head_data;

  // Credit covers both buffered words and the one read still in flight, so a
  // returning word always has a free slot; built only from registered state.
  assign credit_used = count + CNT_WIDTH'(pending_reg);
  assign rd_ready    = !reset && (credit_used < CNT_WIDTH'(BUF_DEPTH));
  assign fire        = rd_ready && !rd_empty;

  always_comb begin
    pending_next = fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign dout_valid = !reset && (count != '0);
  assign dout_data  = reset ? '0 : head_data;
  assign pop        = dout_valid && dout_ready;
  assign buf_count  = count;

  fifo_out_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (pending_reg),
    .push_data(rd_data),
    .pop      (pop),
    .count    (count),
    .head_data(head_data)
  );

  a_credit : assert property (@(posedge clk) disable iff (reset)
    (int'(count) + int'(pending_reg)) <= BUF_DEPTH);

endmodule
